lgdst_ts_ser_tx: RTL

Serial MPEG-TS transmitter, the sending end of the serial TS link (ts_clk/ts_d0/ts_valid/ts_sync) consumed by lgdst_rxglue.
- Accepts 188-byte packets as a byte stream with valid/ready handshake.
- Generates a divided ts_clk and shifts each byte out MSB first.
- Flags sync-byte and underrun errors. Used as TS source on the board and as a bench driver.

---
 rtl/lgdst_ts_ser_tx.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/lgdst_ts_ser_tx.sv
// Serial MPEG-TS transmitter: byte stream with valid/ready in, divided ts_clk
// with MSB-first ts_d0, ts_valid and ts_sync out. Flags sync and underrun errors.
module lgdst_ts_ser_tx #(
  parameter int unsigned PKT_LEN   = 188,
  parameter int unsigned CLK_DIV   = 2,
  parameter logic [7:0]  SYNC_BYTE = 8'h47,
  parameter int unsigned GAP_BITS  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  din,
  input  logic        din_sop,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        ts_clk,
  output logic        ts_d0,
  output logic        ts_valid,
  output logic        ts_sync,
  output logic        err_sync,
  output logic        err_underrun,
  output logic [15:0] pkt_cnt
);

  localparam int unsigned IW = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
  localparam int unsigned DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GW = $clog2(GAP_BITS + 2);

  typedef enum logic [1:0] {IDLE, SEND, STALL, GAP} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_next;
  logic [IW-1:0] byte_idx;
  logic [IW-1:0] load_idx;
  logic [2:0]    bit_idx;
  logic [7:0]    sh;
  logic [7:0]    hold_byte;
  logic          hold_full;
  logic          hold_sop;
  logic          hold_ok;
  logic          div_end;
  logic          fall;
  logic          last;
  logic          load;

  assign din_ready = ~hold_full;
  assign div_end   = (div_cnt == DW'(CLK_DIV - 1));
  assign fall      = div_end & ts_clk;
  assign hold_ok   = hold_full & hold_sop & (hold_byte == SYNC_BYTE);
  assign last      = (byte_idx == IW'(PKT_LEN - 1));
  assign gap_next  = (gap_cnt >= GW'(GAP_BITS)) ? gap_cnt : gap_cnt + GW'(1);

  // gap_next counts the fall being evaluated, so a packet ends at fall F0 and
  // the next one may start at fall F(GAP_BITS); GAP_BITS=0 reloads at F0 itself.
  always_comb begin
    load     = 1'b0;
    load_idx = '0;
    unique case (state)
      IDLE:  load = fall & hold_ok & (gap_next >= GW'(GAP_BITS));
      SEND: begin
        if (fall && bit_idx == 3'd7) begin
          if (last) begin
            load = (GAP_BITS == 0) & hold_ok;
          end else if (hold_full && !hold_sop) begin
            load     = 1'b1;
            load_idx = byte_idx + IW'(1);
          end
        end
      end
      STALL: begin
        if (hold_full && !hold_sop) begin
          load     = 1'b1;
          load_idx = byte_idx + IW'(1);
        end
      end
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      div_cnt      <= '0;
      gap_cnt      <= GW'(GAP_BITS);
      byte_idx     <= '0;
      bit_idx      <= '0;
      sh           <= '0;
      hold_byte    <= '0;
      hold_full    <= 1'b0;
      hold_sop     <= 1'b0;
      ts_clk       <= 1'b0;
      ts_d0        <= 1'b0;
      ts_valid     <= 1'b0;
      ts_sync      <= 1'b0;
      err_sync     <= 1'b0;
      err_underrun <= 1'b0;
      pkt_cnt      <= '0;
    end else begin
      err_sync     <= 1'b0;
      err_underrun <= 1'b0;

      // STALL parks ts_clk low with the timer cleared, so leaving it gives a
      // full low half-period before the next rise.
      if (state == STALL || div_end) begin
        div_cnt <= '0;
        ts_clk  <= (state == STALL) ? 1'b0 : ~ts_clk;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end

      unique case (state)
        IDLE: begin
          if (fall) gap_cnt <= gap_next;
          if (hold_full && !hold_ok) begin
            err_sync  <= 1'b1;
            hold_full <= 1'b0;
          end
        end
        SEND: begin
          if (fall) begin
            if (bit_idx != 3'd7) begin
              ts_d0   <= sh[7];
              sh      <= {sh[6:0], 1'b0};
              bit_idx <= bit_idx + 3'd1;
            end else if (last) begin
              pkt_cnt  <= pkt_cnt + 16'd1;
              gap_cnt  <= '0;
              ts_valid <= 1'b0;
              ts_sync  <= 1'b0;
              ts_d0    <= 1'b0;
              state    <= GAP;
            end else if (!hold_full) begin
              err_underrun <= 1'b1;
              state        <= STALL;
            end else if (hold_sop) begin
              err_sync <= 1'b1;
              gap_cnt  <= '0;
              ts_valid <= 1'b0;
              ts_sync  <= 1'b0;
              ts_d0    <= 1'b0;
              state    <= GAP;
            end
          end
        end
        STALL: begin
          if (hold_full && hold_sop) begin
            err_sync <= 1'b1;
            gap_cnt  <= '0;
            ts_valid <= 1'b0;
            ts_sync  <= 1'b0;
            ts_d0    <= 1'b0;
            state    <= GAP;
          end
        end
        GAP: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (load) begin
        ts_d0     <= hold_byte[7];
        sh        <= {hold_byte[6:0], 1'b0};
        bit_idx   <= '0;
        byte_idx  <= load_idx;
        ts_sync   <= (load_idx == '0);
        ts_valid  <= 1'b1;
        hold_full <= 1'b0;
        state     <= SEND;
      end

      if (din_valid && !hold_full) begin
        hold_full <= 1'b1;
        hold_byte <= din;
        hold_sop  <= din_sop;
      end
    end
  end

endmodule
